// File: rtl/dinorun_pkg.sv
// dinorun_pkg: shared screen geometry, jump physics constants, sprite ids
// and the 1-bpp sprite bitmaps for the dino renderer.
// Bitmap rows are written MSB = leftmost source column.
// DINO_DUCK_EN: when defined, the 28x13 DUCK bitmap is included.
package dinorun_pkg;

  localparam int ScreenWidth  = 640;
  localparam int ScreenHeight = 480;
  localparam int DinoX        = 64;
  localparam int GroundY      = 400;

  localparam int JumpVel  = 12;
  localparam int Gravity  = 1;
  localparam int FastFall = 3;

  // On-screen sizes (source pixels doubled in both axes)
  localparam int BoxW  = 40;
  localparam int BoxH  = 44;
  localparam int DuckW = 56;
  localparam int DuckH = 26;

  typedef enum logic [2:0] {
    SPR_STAND,
    SPR_RUN0,
    SPR_RUN1,
    SPR_DEAD,
    SPR_DUCK
  } sprite_e;

  // Rows 0..17 are shared by STAND, RUN0, RUN1 and DEAD.
  localparam logic [0:17][19:0] BodyRom = {
    20'b00000000001111111100,
    20'b00000000011011111110,
    20'b00000000011111111110,
    20'b00000000011111111110,
    20'b00000000011111000000,
    20'b00000000011111111100,
    20'b10000000111110000000,
    20'b10000001111110000000,
    20'b11000111111111100000,
    20'b11101111111110100000,
    20'b11111111111110000000,
    20'b11111111111110000000,
    20'b01111111111100000000,
    20'b00111111111100000000,
    20'b00011111111000000000,
    20'b00001111110000000000,
    20'b00000111111000000000,
    20'b00000110011000000000
  };

  // Rows 18..21: leg poses, index 0 = standing, 1 = run phase 0, 2 = run phase 1.
  localparam logic [0:2][0:3][19:0] LegRom = {
    20'b00000100001000000000,
    20'b00000100001000000000,
    20'b00000110001100000000,
    20'b00000000000000000000,

    20'b00000100011000000000,
    20'b00000100000000000000,
    20'b00000110000000000000,
    20'b00000000000000000000,

    20'b00000110001000000000,
    20'b00000000001000000000,
    20'b00000000001100000000,
    20'b00000000000000000000
  };

`ifdef DINO_DUCK_EN
  localparam logic [0:12][27:0] DuckRom = {
    28'b0000000000000000000111111110,
    28'b1000000000000000001101111111,
    28'b1100011111111111111111111111,
    28'b1111111111111111111111111111,
    28'b0111111111111111111111111111,
    28'b0011111111111111111111110000,
    28'b0001111111111111111111111100,
    28'b0000111111111111111111000000,
    28'b0000011111111111110000000000,
    28'b0000001100011000000000000000,
    28'b0000001000010000000000000000,
    28'b0000001100011000000000000000,
    28'b0000000000000000000000000000
  };
`endif

endpackage

// File: rtl/dino_sprite_rom.sv
// dino_sprite_rom: combinational sprite bitmap lookup.
//   sprite : which bitmap to read
//   col    : source column (0..19, or 0..27 for DUCK)
//   row    : source row (0..21, or 0..12 for DUCK)
//   pixel  : bitmap bit, 0 outside the bitmap
// DINO_DUCK_EN: when undefined, DUCK always reads as 0.
module dino_sprite_rom
  import dinorun_pkg::*;
(
  input  sprite_e    sprite,
  input  logic [4:0] col,
  input  logic [4:0] row,
  output logic       pixel
);

  logic [4:0] bit_idx;
  logic [1:0] leg_sel;
  logic [1:0] leg_row;

  always_comb begin
    pixel   = 1'b0;
    bit_idx = 5'd19 - col;
    leg_row = 2'(row - 5'd18);
    case (sprite)
      SPR_RUN0: leg_sel = 2'd1;
      SPR_RUN1: leg_sel = 2'd2;
      default:  leg_sel = 2'd0;
    endcase

    if (sprite == SPR_DUCK) begin
`ifdef DINO_DUCK_EN
      if (row < 5'd13 && col < 5'd28)
        pixel = DuckRom[row][5'd27 - col];
`endif
    end else if (row < 5'd22 && col < 5'd20) begin
      if (row < 5'd18)
        pixel = BodyRom[row][bit_idx];
      else
        pixel = LegRom[leg_sel][leg_row][bit_idx];
      // DEAD differs from STAND only in the eye: open eye becomes a mark one row up
      if (sprite == SPR_DEAD && col == 5'd11 && (row == 5'd1 || row == 5'd2))
        pixel = ~pixel;
    end
  end

endmodule

// File: rtl/dino_sprite.sv
// dino_sprite: dino game state (run / jump / duck / dead) updated once per
// frame, plus a registered per-pixel sprite hit test.
//   clk_i, rst_i  : clock, async active-high reset
//   next_frame_i  : one-cycle pulse advancing the game state
//   up_i, down_i  : jump / duck-or-fast-fall requests (levels)
//   hit_i         : collision (level), latches the dead state
//   pixel_x_i/y_i : scan coordinate
//   pixel_o       : 1 = dino pixel at the previous cycle's coordinate
// DINO_DUCK_EN: enables the DUCK sprite and fast fall; otherwise down_i is ignored.
module dino_sprite
  import dinorun_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       next_frame_i,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       hit_i,
  input  logic [9:0] pixel_x_i,
  input  logic [9:0] pixel_y_i,
  output logic       pixel_o
);

  logic [7:0]        height_q;
  logic signed [5:0] vel_q;
  logic              dead_q;
  logic [3:0]        anim_q;   // [2:0] frame count 0..5, [3] leg phase
  logic              duck_q;

  logic              duck_req;
  logic              grounded;
  logic signed [9:0] next_h;
  logic signed [5:0] vel_dec;
  sprite_e           sprite;
  logic [9:0]        top_y;
  logic              in_box;
  logic [4:0]        col;
  logic [4:0]        row;
  logic              rom_bit;

`ifdef DINO_DUCK_EN
  assign duck_req = down_i;
`else
  logic unused_down;
  assign unused_down = down_i;
  assign duck_req    = 1'b0;
`endif

  assign grounded = (height_q == 8'd0);
  assign next_h   = $signed({2'b00, height_q}) + $signed({{4{vel_q[5]}}, vel_q});
  assign vel_dec  = duck_req ? 6'(FastFall) : 6'(Gravity);

  always_comb begin
    if (dead_q)         sprite = SPR_DEAD;
    else if (!grounded) sprite = SPR_STAND;
    else if (duck_q)    sprite = SPR_DUCK;
    else if (anim_q[3]) sprite = SPR_RUN1;
    else                sprite = SPR_RUN0;
  end

  always_comb begin
    top_y = 10'(GroundY - BoxH) - {2'b00, height_q};
    col   = 5'((pixel_x_i - 10'(DinoX)) >> 1);
    if (sprite == SPR_DUCK) begin
      row    = 5'((pixel_y_i - 10'(GroundY - DuckH)) >> 1);
      in_box = (pixel_x_i >= 10'(DinoX)) && (pixel_x_i < 10'(DinoX + DuckW)) &&
               (pixel_y_i >= 10'(GroundY - DuckH)) && (pixel_y_i < 10'(GroundY));
    end else begin
      row    = 5'((pixel_y_i - top_y) >> 1);
      in_box = (pixel_x_i >= 10'(DinoX)) && (pixel_x_i < 10'(DinoX + BoxW)) &&
               (pixel_y_i >= top_y) && (pixel_y_i < top_y + 10'(BoxH));
    end
    if (pixel_x_i >= 10'(ScreenWidth) || pixel_y_i >= 10'(ScreenHeight))
      in_box = 1'b0;
  end

  dino_sprite_rom u_rom (
    .sprite (sprite),
    .col    (col),
    .row    (row),
    .pixel  (rom_bit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      height_q <= '0;
      vel_q    <= '0;
      dead_q   <= 1'b0;
      anim_q   <= '0;
      duck_q   <= 1'b0;
      pixel_o  <= 1'b0;
    end else begin
      // Renders against the state held before this edge's frame update
      pixel_o <= in_box & rom_bit;

      if (next_frame_i && !dead_q) begin
        if (hit_i) begin
          dead_q <= 1'b1;
        end else if (grounded) begin
          if (up_i) begin
            // Launch applies the first frame of motion immediately
            height_q <= 8'(JumpVel);
            vel_q    <= 6'(JumpVel - Gravity);
            duck_q   <= 1'b0;
          end else begin
            duck_q <= duck_req;
            if (!duck_req) begin
              if (anim_q[2:0] == 3'd5) anim_q <= {~anim_q[3], 3'd0};
              else                     anim_q <= anim_q + 4'd1;
            end
          end
        end else if (next_h <= 0) begin
          height_q <= '0;
          vel_q    <= '0;
          duck_q   <= duck_req & ~up_i;
        end else begin
          height_q <= next_h[7:0];
          vel_q    <= vel_q - vel_dec;
        end
      end
    end
  end

endmodule

// File: tb/tb_dino_sprite.sv
module tb_dino_sprite;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       next_frame_i = 1'b0;
  logic       up_i = 1'b0;
  logic       down_i = 1'b0;
  logic       hit_i = 1'b0;
  logic [9:0] pixel_x_i = '0;
  logic [9:0] pixel_y_i = '0;
  logic       pixel_o;

  int tests = 0;
  int fails = 0;

  dino_sprite dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .next_frame_i (next_frame_i),
    .up_i         (up_i),
    .down_i       (down_i),
    .hit_i        (hit_i),
    .pixel_x_i    (pixel_x_i),
    .pixel_y_i    (pixel_y_i),
    .pixel_o      (pixel_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic frame(input logic up, input logic down, input logic hit);
    up_i = up; down_i = down; hit_i = hit;
    next_frame_i = 1'b1;
    tick();
    next_frame_i = 1'b0;
    up_i = 1'b0; down_i = 1'b0; hit_i = 1'b0;
  endtask

  task automatic frames(input int n, input logic up, input logic down);
    for (int i = 0; i < n; i++) frame(up, down, 1'b0);
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic exp);
    pixel_x_i = 10'(x);
    pixel_y_i = 10'(y);
    tick();
    tests++;
    assert (pixel_o === exp) else begin
      fails++;
      $error("FAIL %s: pixel(%0d,%0d) observed %b expected %b", tag, x, y, pixel_o, exp);
    end
  endtask

  // Top row of the 40x44 box: source row 0 col 10 is set, the row above is outside
  task automatic probe_top(input string tag, input int top);
    probe({tag, "_top"}, 84, top, 1'b1);
    probe({tag, "_above"}, 84, top - 1, 1'b0);
  endtask

  initial begin
    #1 rst_i = 1'b1;
    #1;
    tests++;
    assert (pixel_o === 1'b0) else begin
      fails++;
      $error("FAIL reset_pixel: observed %b expected 0", pixel_o);
    end
    tick(); tick();
    rst_i = 1'b0;

    // Idle run from reset
    probe("rst_run0_leg", 74, 394, 1'b1);
    probe("rst_body", 64, 376, 1'b1);
    probe_top("rst", 356);
    frames(5, 1'b0, 1'b0);
    probe("idle_origin", 0, 0, 1'b0);
    probe("idle_left", 63, 380, 1'b0);
    probe("idle_right", 104, 380, 1'b0);
    probe("idle_above", 80, 355, 1'b0);
    probe("idle_offscreen", 700, 380, 1'b0);
    probe("f5_run0_leg", 74, 394, 1'b1);
    probe("f5_run0_gap", 84, 394, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    probe("f6_run1_gap", 74, 394, 1'b0);
    probe("f6_run1_leg", 84, 394, 1'b1);

    // Plain jump: 25 frames, peak 78
    frame(1'b1, 1'b0, 1'b0);
    probe_top("jump_f1", 344);
    frames(11, 1'b0, 1'b0);
    probe_top("jump_f12", 278);
    probe("jump_f12_leg", 74, 318, 1'b1);
    probe("jump_f12_eye", 86, 280, 1'b0);
    frames(12, 1'b0, 1'b0);
    probe_top("jump_f24", 344);
    frame(1'b0, 1'b0, 1'b0);
    probe_top("jump_f25", 356);

`ifdef DINO_DUCK_EN
    // Duck
    frame(1'b0, 1'b1, 1'b0);
    probe("duck_mid", 100, 380, 1'b1);
    probe("duck_right", 118, 380, 1'b1);
    probe("duck_past", 120, 380, 1'b0);
    probe("duck_above", 80, 360, 1'b0);
    probe("duck_top_edge", 64, 373, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    probe("unduck_body", 64, 373, 1'b1);
    probe("unduck_right", 118, 380, 1'b0);

    // Fast fall with up+down held: heights 12,23,31,36 ... land on frame 11
    frame(1'b1, 1'b1, 1'b0);
    probe_top("ff_f1", 344);
    frame(1'b1, 1'b1, 1'b0);
    probe_top("ff_f2", 333);
    frame(1'b1, 1'b1, 1'b0);
    probe_top("ff_f3", 325);
    frame(1'b1, 1'b1, 1'b0);
    probe_top("ff_f4", 320);
    frames(7, 1'b1, 1'b1);
    probe_top("ff_land_f11", 356);
    frame(1'b1, 1'b1, 1'b0);
    probe_top("ff_relaunch", 344);
    frames(24, 1'b0, 1'b0);
    probe_top("ff_relanded", 356);
`else
    // down_i has no effect: same trajectory as a normal jump
    frame(1'b1, 1'b1, 1'b0);
    frames(3, 1'b0, 1'b1);
    probe_top("nodown_f4", 314);
    frames(21, 1'b0, 1'b1);
    probe_top("nodown_f25", 356);
    frame(1'b0, 1'b1, 1'b0);
    probe("nodown_noduck", 64, 373, 1'b1);
`endif

    // Hit mid-jump at height 42
    frame(1'b1, 1'b0, 1'b0);
    frames(3, 1'b0, 1'b0);
    probe("prehit_eye", 86, 316, 1'b0);
    frame(1'b0, 1'b0, 1'b1);
    probe("dead_eye", 86, 316, 1'b1);
    probe("dead_eye_row2", 86, 318, 1'b0);
    probe_top("dead", 314);
    for (int i = 0; i < 40; i++) frame(1'((i % 2) == 1), 1'((i % 4) >= 2), 1'b0);
    probe("dead40_eye", 86, 316, 1'b1);
    probe("dead40_eye_row2", 86, 318, 1'b0);
    probe_top("dead40", 314);

    // Revive, then async reset mid-jump at height 50
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    frame(1'b1, 1'b0, 1'b0);
    frames(4, 1'b0, 1'b0);
    probe("prereset_top", 84, 306, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    tests++;
    assert (pixel_o === 1'b0) else begin
      fails++;
      $error("FAIL async_reset_pixel: observed %b expected 0", pixel_o);
    end
    #1 rst_i = 1'b0;
    probe_top("postreset", 356);
    probe("postreset_run0", 74, 394, 1'b1);

    // hit and up in the same frame: dies on the ground, no launch
    frame(1'b1, 1'b0, 1'b1);
    probe_top("hitup", 356);
    probe("hitup_dead_eye", 86, 358, 1'b1);
    frame(1'b1, 1'b0, 1'b0);
    probe_top("hitup_nolaunch", 356);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
